// File: rtl/pc_ctrl_pkg.sv
// Shared encodings for the PC sequencer: FSM states, jump kinds, PC source selects
// and PC update modes, plus the jump-kind to (mode, cs) decode.
package pc_ctrl_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_UPDATE = 3'd4;
  localparam logic [2:0] ST_HALT   = 3'd5;
  localparam logic [2:0] ST_FAULT  = 3'd6;

  localparam logic [2:0] JK_NONE = 3'd0;
  localparam logic [2:0] JK_BR   = 3'd1;
  localparam logic [2:0] JK_JR0  = 3'd2;
  localparam logic [2:0] JK_JR1  = 3'd3;
  localparam logic [2:0] JK_JIMM = 3'd4;

  localparam logic [1:0] CS_ALU  = 2'd0;
  localparam logic [1:0] CS_REG0 = 2'd1;
  localparam logic [1:0] CS_REG1 = 2'd2;
  localparam logic [1:0] CS_IMM  = 2'd3;

  localparam logic PCM_INC  = 1'b0;
  localparam logic PCM_LOAD = 1'b1;

  function automatic logic jk_legal(input logic [2:0] jk);
    return (jk <= JK_JIMM);
  endfunction

  // Returns {pc_mode, pc_cs}; a branch that is not taken is a plain increment.
  function automatic logic [2:0] pc_sel(input logic [2:0] jk, input logic taken);
    logic [2:0] sel;
    sel = {PCM_INC, CS_ALU};
    case (jk)
      JK_BR:   sel = taken ? {PCM_LOAD, CS_ALU} : {PCM_INC, CS_ALU};
      JK_JR0:  sel = {PCM_LOAD, CS_REG0};
      JK_JR1:  sel = {PCM_LOAD, CS_REG1};
      JK_JIMM: sel = {PCM_LOAD, CS_IMM};
      default: sel = {PCM_INC, CS_ALU};
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/pc_fetch_timer.sv
// Counts cycles spent in FETCH; the first FETCH cycle reads as 1, and expired flags
// the cycle whose count equals TIMEOUT (never, when TIMEOUT is 0).
module pc_fetch_timer
  import pc_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int TMR_W   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam logic [TMR_W-1:0] LIMIT = TMR_W'(TIMEOUT);

  logic [TMR_W-1:0] cnt_q;
  logic [TMR_W-1:0] cnt_d;

  // Saturating so a disabled timeout can sit in FETCH forever without wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = TMR_W'(1);
    end else if (count_en && (cnt_q != '1)) begin
      cnt_d = cnt_q + TMR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (TIMEOUT != 0) && (cnt_q == LIMIT);

endmodule

// File: rtl/pc_seq_ctrl.sv
// Multicycle PC sequencer: fetch, decode, execute, then exactly one PC update per
// instruction. All outputs are Moore-decoded from registered state.
module pc_seq_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 16,
  parameter int TMR_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  output logic             im_req,
  input  logic             im_ack,
  input  logic             dec_valid,
  input  logic [2:0]       jump_kind,
  input  logic             br_taken,
  input  logic             exec_done,
  input  logic             halt_req,
  output logic [1:0]       pc_cs,
  output logic             pc_mode,
  output logic             pc_en,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] retired_cnt
);

  logic [2:0]       state_q, state_d;
  logic [2:0]       kind_q, kind_d;
  logic             taken_q, taken_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmr_clear;
  logic             tmr_expired;

  // Handshakes: im_req is held for the whole of FETCH and a transfer completes on
  // the first edge where im_ack is high; dec_valid, exec_done and halt_req are
  // level inputs that only matter in DECODE, EXEC and UPDATE respectively.
  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    taken_d = taken_q;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        if (im_ack) begin
          state_d = ST_DECODE;
        end else if (tmr_expired) begin
          state_d = ST_FAULT;
        end
      end
      ST_DECODE: begin
        if (dec_valid) begin
          if (!jk_legal(jump_kind)) begin
            state_d = ST_FAULT;
          end else begin
            kind_d  = jump_kind;
            taken_d = br_taken;
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        if (exec_done) begin
          state_d = ST_UPDATE;
        end
      end
      ST_UPDATE: state_d = halt_req ? ST_HALT : ST_FETCH;
      ST_HALT:   state_d = ST_HALT;
      ST_FAULT:  state_d = ST_FAULT;
      default:   state_d = ST_FAULT;
    endcase
  end

  assign cnt_d = (state_q == ST_UPDATE) ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      kind_q  <= JK_NONE;
      taken_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      taken_q <= taken_d;
      cnt_q   <= cnt_d;
    end
  end

  assign tmr_clear = (state_d == ST_FETCH) && (state_q != ST_FETCH);

  pc_fetch_timer #(
    .TIMEOUT(TIMEOUT),
    .TMR_W  (TMR_W)
  ) u_fetch_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (tmr_clear),
    .count_en(state_q == ST_FETCH),
    .expired (tmr_expired)
  );

  assign im_req      = (state_q == ST_FETCH);
  assign pc_en       = (state_q == ST_UPDATE);
  assign halted      = (state_q == ST_HALT);
  assign fault       = (state_q == ST_FAULT);
  assign retired_cnt = cnt_q;

  always_comb begin
    {pc_mode, pc_cs} = {PCM_INC, CS_ALU};
    if (pc_en) begin
      {pc_mode, pc_cs} = pc_sel(kind_q, taken_q);
    end
  end

endmodule
